// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared types and constants for the motor PWM driver
// Contents: drive_cmd_e (steering commands), wheel_state_e (per-wheel ramp FSM),
//           DIR_FWD / DIR_REV H-bridge direction encodings.
package drive_pkg;

    typedef enum logic [2:0] {
        CMD_STOP       = 3'd0,
        CMD_FAST_LEFT  = 3'd1,
        CMD_LEFT       = 3'd2,
        CMD_STRAIGHT   = 3'd3,
        CMD_RIGHT      = 3'd4,
        CMD_FAST_RIGHT = 3'd5
    } drive_cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DECEL = 2'd2
    } wheel_state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/wheel_ramp.sv
// rtl/wheel_ramp.sv - per-wheel slew-limited duty/direction FSM
// Ports: clk, reset (async, active-high), tick (ramp strobe), target_dir, target_duty in;
//        duty, dir out (registered). Direction only changes while duty is zero.
module wheel_ramp
    import drive_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                target_dir,
    input  logic [PWM_BITS-1:0] target_duty,
    output logic [PWM_BITS-1:0] duty,
    output logic                dir
);

    // One extra bit so sums and differences never wrap.
    localparam int W = PWM_BITS + 1;
    localparam logic [W-1:0] STEP = W'(RAMP_STEP);

    wheel_state_e        state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;

    logic [W-1:0] duty_w, tgt_w, up_w, decel_w, toward_w;

    always_comb begin
        duty_w  = {1'b0, duty_q};
        tgt_w   = {1'b0, target_duty};
        up_w    = duty_w + STEP;
        decel_w = (duty_w <= STEP) ? '0 : duty_w - STEP;
        // Move toward a non-zero target, landing exactly on it.
        if (duty_w < tgt_w) begin
            toward_w = (up_w >= tgt_w) ? tgt_w : up_w;
        end else if ((duty_w - tgt_w) <= STEP) begin
            toward_w = tgt_w;
        end else begin
            toward_w = duty_w - STEP;
        end

        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    // Direction is latched here, at zero duty, together with the first step.
                    if (target_duty != '0) begin
                        dir_d   = target_dir;
                        duty_d  = toward_w[PWM_BITS-1:0];
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    if ((target_duty == '0) || (target_dir != dir_q)) begin
                        duty_d  = decel_w[PWM_BITS-1:0];
                        state_d = (decel_w == '0) ? IDLE : DECEL;
                    end else begin
                        duty_d = toward_w[PWM_BITS-1:0];
                    end
                end
                DECEL: begin
                    duty_d  = decel_w[PWM_BITS-1:0];
                    state_d = (decel_w == '0) ? IDLE : DECEL;
                end
                default: begin
                    duty_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            dir_q   <= DIR_FWD;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
        end
    end

    assign duty = duty_q;
    assign dir  = dir_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - steering command to two-wheel PWM + direction driver
// Ports: clk, reset (async, active-high), drive_command[2:0], valid in;
//        pwm_left, pwm_right, dir_left, dir_right, timeout out (all registered).
// Option: define MOTOR_WATCHDOG_EN to force Stop after TIMEOUT_CYCLES without valid.
module motor_pwm_driver
    import drive_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int DUTY_FAST      = 240,
    parameter int DUTY_SLOW      = 128,
    parameter int RAMP_DIV       = 50000,
    parameter int RAMP_STEP      = 8,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] drive_command,
    input  logic       valid,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic       dir_left,
    output logic       dir_right,
    output logic       timeout
);

    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'(DUTY_FAST);
    localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'(DUTY_SLOW);

    if (RAMP_DIV < 1 || RAMP_STEP < 1 || TIMEOUT_CYCLES < 1 || DUTY_FAST >= 2 ** PWM_BITS) begin : g_param_check
        $error("motor_pwm_driver: illegal parameter value");
    end

    logic [2:0]          cmd_q, cmd_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
    logic                tick;
    logic                tdir_l, tdir_r;
    logic [PWM_BITS-1:0] tduty_l, tduty_r, duty_l, duty_r;

`ifdef MOTOR_WATCHDOG_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    // valid has priority over expiry; the counter saturates so Stop is forced once.
    always_comb begin
        cmd_d     = cmd_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (valid) begin
            cmd_d     = drive_command;
            wd_d      = '0;
            timeout_d = 1'b0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_MAX - 1'b1) begin
                cmd_d     = CMD_STOP;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    always_comb begin
        cmd_d = valid ? drive_command : cmd_q;
    end

    assign timeout = 1'b0;
`endif

    // Shared ramp divider: tick is high for the last cycle of each RAMP_DIV period.
    always_comb begin
        tick  = (div_q == DIV_W'(RAMP_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
    end

    // Target decode; codes 6/7 fall into the Stop default.
    always_comb begin
        tdir_l  = DIR_FWD;
        tdir_r  = DIR_FWD;
        tduty_l = '0;
        tduty_r = '0;
        case (cmd_q)
            CMD_FAST_LEFT:  begin tdir_l = DIR_REV; tduty_l = FAST; tduty_r = FAST; end
            CMD_LEFT:       begin tduty_l = SLOW; tduty_r = FAST; end
            CMD_STRAIGHT:   begin tduty_l = FAST; tduty_r = FAST; end
            CMD_RIGHT:      begin tduty_l = FAST; tduty_r = SLOW; end
            CMD_FAST_RIGHT: begin tdir_r = DIR_REV; tduty_l = FAST; tduty_r = FAST; end
            default:        ;
        endcase
    end

    wheel_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_wheel_left (
        .clk(clk), .reset(reset), .tick(tick), .target_dir(tdir_l),
        .target_duty(tduty_l), .duty(duty_l), .dir(dir_left)
    );

    wheel_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_wheel_right (
        .clk(clk), .reset(reset), .tick(tick), .target_dir(tdir_r),
        .target_duty(tduty_r), .duty(duty_r), .dir(dir_right)
    );

    always_comb begin
        pwm_l_d = ({1'b0, duty_l} > {1'b0, cnt_q});
        pwm_r_d = ({1'b0, duty_r} > {1'b0, cnt_q});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q   <= CMD_STOP;
            div_q   <= '0;
            cnt_q   <= '0;
            pwm_l_q <= 1'b0;
            pwm_r_q <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pwm_l_q <= pwm_l_d;
            pwm_r_q <= pwm_r_d;
        end
    end

    assign pwm_left  = pwm_l_q;
    assign pwm_right = pwm_r_q;

endmodule
